multi_seq_nbit: RTL and testbench

Sequential shift-add multiplier, parametrised in operand width, with an unsigned/two's-complement mode select and a start/busy/done handshake. It is the clocked successor to the combinational 8-bit multiplier in the ALU datapath. It trades latency (one cycle per operand bit) for area. Its result feeds the ALU result mux when the multiply opcode is selected.

---
 rtl/multi_seq_nbit.sv | 137 +++++++++++++
 tb/tb_multi_seq_nbit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_seq_nbit.sv
// multi_seq_nbit: sequential shift-add multiplier with unsigned / two's-complement modes.
//
// One operand bit is consumed per clock, so a product takes WIDTH cycles in RUN plus a
// one-cycle DONE pulse. Signed operands are reduced to magnitudes at load time and the
// result is negated once at completion, so the core loop is a plain unsigned shift-add.
//
// Parameters:
//   WIDTH  operand width in bits (2..32); product is 2*WIDTH bits.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst    synchronous, active-high reset (wins over start)
//   start  request; accepted in IDLE or DONE, ignored while busy
//   sgn    1 = operands are two's complement, 0 = unsigned (sampled with start)
//   a      multiplicand (sampled with start)
//   b      multiplier (sampled with start)
//   p      registered product; holds the last completed result
//   busy   high for the WIDTH cycles of an operation
//   done   one-cycle pulse in the cycle p carries a new result

module multi_seq_nbit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done
);

    // Counter only has to reach WIDTH-1; WIDTH >= 2 keeps this at least one bit wide.
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e               state_q;
    logic [2*WIDTH-1:0]   acc_q;     // upper half accumulates, lower half collects shifted-out bits
    logic [WIDTH-1:0]     mcand_q;   // |a|
    logic [WIDTH-1:0]     mplier_q;  // |b|, consumed LSB first
    logic                 neg_q;     // final result must be negated
    logic [CntW-1:0]      cnt_q;
    logic [2*WIDTH-1:0]   p_q;
    logic                 busy_q;
    logic                 done_q;

    // Load-time operand conditioning
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg_load;

    // One shift-add step
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_final;
    logic                 last_iter;

    always_comb begin
        // The most negative operand negates to itself, which read as unsigned is the
        // correct magnitude 2^(WIDTH-1).
        a_mag    = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag    = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        neg_load = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    always_comb begin
        // Add is WIDTH+1 bits wide so the carry lands in the top bit after the shift.
        sum        = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
        acc_step   = {sum, acc_q[WIDTH-1:1]};
        prod_final = neg_q ? (~acc_step + (2*WIDTH)'(1)) : acc_step;
        last_iter  = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                // DONE accepts start exactly like IDLE to allow back-to-back operation.
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= neg_load;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end else begin
                        state_q  <= StIdle;
                    end
                end

                // start is ignored here; operands were captured at load.
                StRun: begin
                    acc_q    <= acc_step;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (last_iter) begin
                        p_q     <= prod_final;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign p    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_multi_seq_nbit.sv
// Testbench for multi_seq_nbit: WIDTH=8 and WIDTH=4 instances on a shared clock/reset.
// A posedge process records accepted requests with their model products; a negedge monitor
// per instance checks busy every cycle and pops/compares on each done pulse.

module tb_multi_seq_nbit;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, sgn = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic [15:0] p;
    logic        busy, done;
    logic        start4 = 1'b0, sgn4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  p4;
    logic        busy4, done4;

    always #5 clk = ~clk;

    multi_seq_nbit #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
        .p(p), .busy(busy), .done(done)
    );

    multi_seq_nbit #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
        .p(p4), .busy(busy4), .done(done4)
    );

    typedef struct {
        longint      st;   // edge index at which start was accepted
        logic [15:0] exp;
    } op_t;

    op_t         pend8[$];
    op_t         pend4[$];
    longint      cyc = 0;
    longint      rst_at = -1;
    longint      free8 = 0, free4 = 0;
    logic [15:0] exp_p8 = '0, exp_p4 = '0;
    logic        eb8, due8, eb4, due4;
    int          checks = 0, errors = 0;

    // Reference: interpret operands as integers and multiply, keep 2*w low bits.
    function automatic logic [15:0] model(input int w, input logic s,
                                          input logic [7:0] x, input logic [7:0] y);
        longint vx = longint'(x);
        longint vy = longint'(y);
        longint m  = longint'(1) << w;
        longint pr;
        if (s && vx >= m / 2) vx = vx - m;
        if (s && vy >= m / 2) vy = vy - m;
        pr = vx * vy;
        pr = pr & ((longint'(1) << (2 * w)) - 1);
        return 16'(pr);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    // Request acceptance as seen from the outside: a start is taken whenever no operation
    // is still running (the next one may begin WIDTH+1 edges after the previous start).
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend8.delete();
            pend4.delete();
            free8  = cyc + 1;
            free4  = cyc + 1;
            rst_at = cyc;
        end else begin
            if (start && cyc >= free8) begin
                pend8.push_back('{cyc, model(W8, sgn, a, b)});
                free8 = cyc + W8 + 1;
            end
            if (start4 && cyc >= free4) begin
                pend4.push_back('{cyc, model(W4, sgn4, {4'b0, a4}, {4'b0, b4})});
                free4 = cyc + W4 + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_at == cyc) exp_p8 = '0;
        due8 = pend8.size() > 0 && pend8[0].st + W8 == cyc;
        eb8  = pend8.size() > 0 && cyc >= pend8[0].st && cyc < pend8[0].st + W8;
        check("busy8", longint'(busy), longint'(eb8));
        if (done) begin
            if (pend8.size() == 0) check("unexpected_done8", 1, 0);
            else begin
                check("latency8", cyc - pend8[0].st, W8);
                exp_p8 = pend8[0].exp;
                void'(pend8.pop_front());
            end
        end else if (due8) begin
            check("missing_done8", 0, 1);
            void'(pend8.pop_front());
        end
        check("p8", longint'(p), longint'(exp_p8));
    end

    always @(negedge clk) begin
        if (rst_at == cyc) exp_p4 = '0;
        due4 = pend4.size() > 0 && pend4[0].st + W4 == cyc;
        eb4  = pend4.size() > 0 && cyc >= pend4[0].st && cyc < pend4[0].st + W4;
        check("busy4", longint'(busy4), longint'(eb4));
        if (done4) begin
            if (pend4.size() == 0) check("unexpected_done4", 1, 0);
            else begin
                check("latency4", cyc - pend4[0].st, W4);
                exp_p4 = {8'b0, pend4[0].exp[7:0]};
                void'(pend4.pop_front());
            end
        end else if (due4) begin
            check("missing_done4", 0, 1);
            void'(pend4.pop_front());
        end
        check("p4", longint'(p4), longint'(exp_p4));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until the 8-bit unit can take a request, pulse start once, then scramble
    // operands so anything sampled while busy would corrupt the result.
    task automatic issue8(input logic s, input logic [7:0] x, input logic [7:0] y);
        int g = 0;
        while (cyc + 1 < free8 && g < 100) begin
            tick();
            g++;
        end
        start = 1'b1; sgn = s; a = x; b = y;
        tick();
        start = 1'b0; sgn = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
    endtask

    task automatic issue4(input logic s, input logic [3:0] x, input logic [3:0] y);
        int g = 0;
        while (cyc + 1 < free4 && g < 100) begin
            tick();
            g++;
        end
        start4 = 1'b1; sgn4 = s; a4 = x; b4 = y;
        tick();
        start4 = 1'b0; sgn4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
    endtask

    logic        dir_s [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [7:0]  dir_a [8] = '{8'd1, 8'd7, 8'd255, 8'd0, 8'hFF, 8'h80, 8'h80, 8'h05};
    logic [7:0]  dir_b [8] = '{8'd22, 8'd10, 8'd255, 8'd200, 8'hFF, 8'h7F, 8'h80, 8'hFD};

    initial begin
        repeat (2) tick();
        rst = 1'b0;

        issue4(1'b0, 4'd15, 4'd15);
        issue4(1'b1, 4'h8, 4'h8);
        for (int i = 0; i < 8; i++) issue8(dir_s[i], dir_a[i], dir_b[i]);

        // Back-to-back with start held high; second operands appear in the DONE cycle.
        issue8(1'b0, 8'd0, 8'd0);
        while (cyc + 1 < free8) tick();
        start = 1'b1; sgn = 1'b0; a = 8'd3; b = 8'd4;
        tick();
        repeat (W8) tick();
        a = 8'd6; b = 8'd7;
        tick();
        start = 1'b0;

        // Reset in the 4th RUN cycle of 100*100, then a fresh 2*3.
        while (cyc + 1 < free8) tick();
        issue8(1'b0, 8'd100, 8'd100);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        issue8(1'b0, 8'd2, 8'd3);

        // Random traffic: start pulses and operand changes every cycle, including while busy.
        for (int i = 0; i < 400; i++) begin
            start  = ($urandom_range(0, 2) == 0);
            sgn    = 1'($urandom);
            a      = 8'($urandom);
            b      = 8'($urandom);
            start4 = ($urandom_range(0, 2) == 0);
            sgn4   = 1'($urandom);
            a4     = 4'($urandom);
            b4     = 4'($urandom);
            if (i == 250) rst = 1'b1;
            else rst = 1'b0;
            tick();
        end
        start = 1'b0; start4 = 1'b0; rst = 1'b0;
        repeat (W8 + 3) tick();
        check("drain8", longint'(pend8.size()), 0);
        check("drain4", longint'(pend4.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

endmodule
